// File: rtl/cheat_pkg.sv
// Shared constants and state encoding for the cheat download path.
// Code word layout is {strobe, flags, address, compare, replace}.
package cheat_pkg;

  localparam int CODE_W       = 129;
  localparam int STROBE       = 128;
  localparam int FLAGS        = 96;
  localparam int ADDR         = 64;
  localparam int COMP         = 32;
  localparam int REPL         = 0;
  localparam int RECORD_BYTES = 16;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW
  } state_t;

  // Record slots 0-3 are flags, 4-7 address, 8-11 compare, 12-15 replace, each little-endian.
  function automatic int slotLsb(input logic [3:0] slot);
    int base;
    case (slot[3:2])
      2'd0:    base = FLAGS;
      2'd1:    base = ADDR;
      2'd2:    base = COMP;
      default: base = REPL;
    endcase
    return base + 8 * int'(slot[1:0]);
  endfunction

endpackage

// File: rtl/cheat_loader_if.sv
// Bundle of the HPS byte-download side and the cheat-engine code bus.
// The loader sits on the slave modport; the download source / observer uses master.
interface cheat_loader_if
  import cheat_pkg::*;
#(
  parameter int MAX_CODES = 32
);

  localparam int CNT_W = $clog2(MAX_CODES) + 1;

  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [CODE_W-1:0] code;
  logic              codes_reset;
  logic [CNT_W-1:0]  code_count;
  logic              busy;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, code, codes_reset, code_count, busy
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, code, codes_reset, code_count, busy
  );

endinterface

// File: rtl/cheat_loader.sv
// Assembles 16-byte cheat records from the download stream and delivers them
// one at a time on the toggle-strobed code bus, with a clear pulse per download.
module cheat_loader
  import cheat_pkg::*;
#(
  parameter int MAX_CODES    = 32,
  parameter int HOLD_CYCLES  = 2,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  cheat_loader_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_CODES) + 1;

  state_t            state_q;
  logic [7:0]        timer_q;
  logic [CODE_W-1:0] code_q;
  logic [CNT_W-1:0]  count_q;
  logic [127:0]      asmWord_q;
  logic [127:0]      asmWord_d;
  logic [127:0]      pendWord_q;
  logic              pendValid_q;
  logic              dlPrev_q;

  logic dlRise;
  logic dlFall;
  logic waitOut;
  logic wrAccept;

  assign dlRise   = bus.ioctl_download & ~dlPrev_q;
  assign dlFall   = ~bus.ioctl_download & dlPrev_q;
  assign waitOut  = pendValid_q | (state_q == S_CLEAR);
  // A byte arriving with the download rising edge is dropped: the clear wins.
  assign wrAccept = bus.ioctl_wr & bus.ioctl_download & ~dlRise & ~waitOut;

  always_comb begin
    asmWord_d = asmWord_q;
    asmWord_d[slotLsb(bus.ioctl_addr[3:0]) +: 8] = bus.ioctl_dout;
  end

  always_ff @(posedge clk) begin
    dlPrev_q <= bus.ioctl_download;
    if (reset || dlRise) begin
      state_q     <= S_CLEAR;
      timer_q     <= '0;
      code_q      <= '0;
      count_q     <= '0;
      asmWord_q   <= '0;
      pendWord_q  <= '0;
      pendValid_q <= 1'b0;
    end else begin
      if (wrAccept) begin
        asmWord_q <= asmWord_d;
        if (bus.ioctl_addr[3:0] == 4'hF) begin
          pendWord_q  <= asmWord_d;
          pendValid_q <= 1'b1;
        end
      end else if (dlFall) begin
        asmWord_q <= '0;
      end

      case (state_q)
        S_CLEAR: begin
          code_q      <= '0;
          count_q     <= '0;
          asmWord_q   <= '0;
          pendValid_q <= 1'b0;
          if (timer_q == 8'(CLEAR_CYCLES - 1)) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_IDLE: begin
          if (pendValid_q) begin
            if (count_q < CNT_W'(MAX_CODES)) begin
              code_q[127:0] <= pendWord_q;
              state_q       <= S_SETUP;
            end else begin
              pendValid_q <= 1'b0;
            end
          end
        end
        S_SETUP: begin
          code_q[STROBE] <= 1'b1;
          count_q        <= count_q + 1'b1;
          timer_q        <= '0;
          state_q        <= S_HIGH;
        end
        S_HIGH: begin
          if (timer_q == 8'(HOLD_CYCLES - 1)) begin
            code_q[STROBE] <= 1'b0;
            timer_q        <= '0;
            state_q        <= S_LOW;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_LOW: begin
          if (timer_q == 8'(HOLD_CYCLES - 1)) begin
            pendValid_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= S_IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign bus.ioctl_wait  = waitOut;
  assign bus.code        = code_q;
  assign bus.codes_reset = (state_q == S_CLEAR);
  assign bus.code_count  = count_q;
  assign bus.busy        = (state_q != S_IDLE) | pendValid_q;

endmodule

// File: tb/tb_cheat_loader.sv
// Scoreboard bench for cheat_loader: records are queued as they are written and a
// monitor pops and compares on every strobe rising edge.
module tb_cheat_loader;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cheat_loader_if #(.MAX_CODES(32)) bus ();

  cheat_loader #(
    .MAX_CODES   (32),
    .HOLD_CYCLES (2),
    .CLEAR_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [127:0] word;
    int           count;
  } exp_t;

  exp_t         expQ[$];
  int           checks      = 0;
  int           passes      = 0;
  int           strobeCount = 0;
  int           modelCount  = 0;
  int           stallCount  = 0;
  bit           hung        = 0;
  logic         prevStrobe  = 1'b0;
  logic [127:0] prevData    = '0;

  task automatic checkOutput(input string name, input logic [128:0] actual,
                             input logic [128:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
  endtask

  // Monitor: every strobe rise must match the oldest queued record, with data held from the prior cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.code[128] && !prevStrobe) begin
      strobeCount++;
      checkOutput("dataStableBeforeRise", 129'(bus.code[127:0]), 129'(prevData));
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpectedStrobe: got code 0x%0h, wanted no delivery", bus.code[127:0]);
      end else begin
        e = expQ.pop_front();
        checkOutput("codeWord", 129'(bus.code[127:0]), 129'(e.word));
        checkOutput("codeCountAtRise", 129'(bus.code_count), 129'(e.count));
      end
    end
    prevStrobe = bus.code[128];
    prevData   = bus.code[127:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeByte(input logic [24:0] addr, input logic [7:0] data);
    int budget = 0;
    while (bus.ioctl_wait && !hung) begin
      bus.ioctl_wr = 1'b0;
      stallCount++;
      tick();
      budget++;
      if (budget >= 200) begin
        checks++;
        hung = 1;
        $display("[TB] FAIL writeTimeout: got ioctl_wait=1 for %0d cycles, wanted release", budget);
      end
    end
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    tick();
  endtask

  task automatic applyStimulus(input logic [7:0] b[16], input int recIdx);
    exp_t e;
    if (modelCount < 32) begin
      modelCount++;
      e.word  = {b[3], b[2], b[1], b[0], b[7], b[6], b[5], b[4],
                 b[11], b[10], b[9], b[8], b[15], b[14], b[13], b[12]};
      e.count = modelCount;
      expQ.push_back(e);
    end
    for (int i = 0; i < 16; i++) writeByte(25'(recIdx * 16 + i), b[i]);
  endtask

  task automatic genRec(input int r, output logic [7:0] b[16]);
    for (int i = 0; i < 16; i++) b[i] = 8'(r * 7 + i * 13 + 1);
  endtask

  task automatic startDownload();
    bus.ioctl_download = 1'b1;
    modelCount = 0;
    tick();
  endtask

  task automatic endDownload();
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  task automatic waitIdle(input string name);
    int budget = 0;
    while ((bus.busy || expQ.size() != 0) && budget < 400) begin
      tick();
      budget++;
    end
    if (budget >= 400) begin
      checks++;
      $display("[TB] FAIL %s: got busy=%0b queued=%0d after %0d cycles, wanted idle",
               name, bus.busy, expQ.size(), budget);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500000, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rec[16];
    logic [7:0] rec1[16];
    int hi;
    int snapStall;
    int snapStrobe;
    int budget;

    rec1 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00,
             8'hAA, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00};

    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("resetCodesReset", 129'(bus.codes_reset), 129'(1));
    checkOutput("resetCode", bus.code, 129'(0));
    checkOutput("resetCodeCount", 129'(bus.code_count), 129'(0));
    checkOutput("resetWait", 129'(bus.ioctl_wait), 129'(1));
    checkOutput("resetBusy", 129'(bus.busy), 129'(1));
    tick();
    reset = 1'b0;
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.codes_reset) hi++;
    end
    checkOutput("clearPulseAfterReset", 129'(hi), 129'(4));

    // Single hand-computed record.
    tick();
    startDownload();
    applyStimulus(rec1, 0);
    bus.ioctl_wr = 1'b0;
    waitIdle("idleAfterRecord1");
    checkOutput("record1Word", 129'(bus.code[127:0]),
                129'(128'h00000001_00001234_000000AA_00000055));
    checkOutput("record1Count", 129'(bus.code_count), 129'(1));
    checkOutput("record1StrobeLow", 129'(bus.code[128]), 129'(0));
    endDownload();

    // Three records streamed one byte per cycle; each boundary stalls 2*HOLD+2 cycles.
    startDownload();
    snapStrobe = strobeCount;
    genRec(0, rec);
    applyStimulus(rec, 0);
    snapStall = stallCount;
    genRec(1, rec);
    applyStimulus(rec, 1);
    genRec(2, rec);
    applyStimulus(rec, 2);
    bus.ioctl_wr = 1'b0;
    checkOutput("backToBackStalls", 129'(stallCount - snapStall), 129'(12));
    waitIdle("idleAfterThree");
    checkOutput("threeCount", 129'(bus.code_count), 129'(3));
    checkOutput("threeStrobes", 129'(strobeCount - snapStrobe), 129'(3));
    endDownload();

    // 34 records against a 32-entry engine.
    startDownload();
    snapStrobe = strobeCount;
    for (int r = 0; r < 34; r++) begin
      genRec(r + 10, rec);
      applyStimulus(rec, r);
    end
    bus.ioctl_wr = 1'b0;
    waitIdle("idleAfterOverflow");
    checkOutput("overflowCount", 129'(bus.code_count), 129'(32));
    checkOutput("overflowStrobes", 129'(strobeCount - snapStrobe), 129'(32));
    checkOutput("overflowWaitReleased", 129'(bus.ioctl_wait), 129'(0));
    endDownload();

    // Download ends part-way through the second record.
    startDownload();
    snapStrobe = strobeCount;
    genRec(50, rec);
    applyStimulus(rec, 0);
    genRec(51, rec);
    for (int i = 0; i < 10; i++) writeByte(25'(16 + i), rec[i]);
    endDownload();
    waitIdle("idleAfterPartial");
    repeat (10) tick();
    checkOutput("partialCount", 129'(bus.code_count), 129'(1));
    checkOutput("partialStrobes", 129'(strobeCount - snapStrobe), 129'(1));

    // New download rise while the strobe is high aborts the delivery.
    startDownload();
    genRec(60, rec);
    applyStimulus(rec, 0);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.code[128] && budget < 50);
    if (budget >= 50) begin
      checks++;
      $display("[TB] FAIL strobeTimeout: got no strobe in %0d cycles, wanted a rise", budget);
    end
    bus.ioctl_download = 1'b1;
    modelCount = 0;
    @(negedge clk);
    checkOutput("abortStrobeLow", 129'(bus.code[128]), 129'(0));
    checkOutput("abortCode", bus.code, 129'(0));
    checkOutput("abortCount", 129'(bus.code_count), 129'(0));
    hi = bus.codes_reset ? 1 : 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.codes_reset) hi++;
    end
    checkOutput("abortClearPulse", 129'(hi), 129'(4));

    // Byte coinciding with the download rise is dropped; next record assembles from slot 0.
    tick();
    bus.ioctl_download = 1'b0;
    repeat (2) tick();
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_addr     = 25'd3;
    bus.ioctl_dout     = 8'hEE;
    modelCount = 0;
    tick();
    bus.ioctl_wr = 1'b0;
    snapStrobe = strobeCount;
    genRec(70, rec);
    applyStimulus(rec, 0);
    bus.ioctl_wr = 1'b0;
    waitIdle("idleAfterRiseByte");
    checkOutput("riseByteCount", 129'(bus.code_count), 129'(1));
    checkOutput("riseByteStrobes", 129'(strobeCount - snapStrobe), 129'(1));
    endDownload();

    repeat (4) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cheat_loader.md
# cheat_loader

Front end of the cheat path. Takes the byte stream of a cheat file from the HPS download interface, assembles 16-byte records into 128-bit code words, and presents them one at a time on the 129-bit toggle-strobed code bus consumed by the cheat engine. It also generates the engine's clear pulse at the start of each download and paces deliveries so none are lost.

## Interface
- MAX_CODES, 32: engine capacity; records beyond this are consumed and dropped.
- HOLD_CYCLES, 2: cycles the strobe bit stays high, and also stays low, per delivery; minimum 1.
- CLEAR_CYCLES, 4: length of the codes_reset pulse.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high; same effect as a new download start
- ioctl_download  in  1  high for the duration of a cheat file download
- ioctl_wr  in  1  byte strobe, one cycle per byte
- ioctl_addr  in  25  byte offset within the file
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  upstream must not assert ioctl_wr while high
- code  out  129  {strobe, flags[31:0], address[31:0], compare[31:0], replace[31:0]}
- codes_reset  out  1  clear pulse to the cheat engine
- code_count  out  $clog2(MAX_CODES)+1  codes delivered since the last clear
- busy  out  1  clearing, or record pending or being emitted

## Operation
- Record layout: bytes 0–3 flags, 4–7 address, 8–11 compare, 12–15 replace. Fields are little-endian; byte k of a field goes to field bits [8k+7:8k]. The byte slot is ioctl_addr[3:0].
- Assembly register (128 bits) plus one pending register with a valid flag.
- Each accepted write stores the byte in the slot given by ioctl_addr[3:0].
- A write to slot 15 completes the record. The assembled word, including byte 15, moves to pending and pending is marked valid.
- ioctl_wait = pending_valid OR state==CLEAR.
- FSM states: CLEAR, IDLE, SETUP, HIGH, LOW.
  - CLEAR: codes_reset=1 for CLEAR_CYCLES. code cleared to 0, code_count cleared to 0, pending invalidated, assembly cleared. Then go to IDLE.
  - IDLE: if pending_valid and code_count<MAX_CODES, load code[127:0] from pending (strobe stays 0) and go to SETUP. If pending_valid and code_count==MAX_CODES, drop pending and stay in IDLE.
  - SETUP: one cycle, data stable with strobe 0. Set code[128]=1, increment code_count, go to HIGH.
  - HIGH: hold for HOLD_CYCLES. Clear code[128] and go to LOW.
  - LOW: hold for HOLD_CYCLES. Invalidate pending and go to IDLE.
- code[127:0] holds the last delivered record until the next load or CLEAR.
- Rising edge of ioctl_download goes to CLEAR from any state. This aborts any emission in flight and drops strobe to 0 immediately.
- Falling edge of ioctl_download discards a partial assembly. A valid pending record is still delivered.
- Writes while ioctl_download is low are ignored.

## Timing
- Reset values: code=0, codes_reset=1 (the reset enters CLEAR), code_count=0, ioctl_wait=1, busy=1.
- Record-complete to strobe rise: 2 cycles (IDLE load, SETUP).
- Strobe period per code: 2*HOLD_CYCLES+2 cycles. Data is stable at least 1 cycle before the rising edge.
- ioctl_wait rises the cycle after the slot-15 write. It falls the cycle after LOW completes, or after a drop.
- Simultaneous download rising edge and ioctl_wr: CLEAR wins and the byte is discarded.
- code_count saturates at MAX_CODES.

## Structure
- Package cheat_pkg holds: CODE_W=129, field offsets (STROBE=128, FLAGS=96, ADDR=64, COMP=32, REPL=0), RECORD_BYTES=16, and the state enum.
- No sub-module is required. Optionally, cheat_rec_asm (byte-to-128-bit assembler) can be split out.

## Test plan
- Reset, then one record with bytes 0x01,0,0,0, 0x34,0x12,0,0, 0xAA,0,0,0, 0x55,0,0,0 → one strobe rise with code[127:0] = 0x00000001_00001234_000000AA_00000055 and code_count=1.
- 3 records back-to-back at one byte/cycle → ioctl_wait stalls the stream, 3 distinct strobe rises, each preceded by stable data, code_count=3.
- 34 records with MAX_CODES=32 → exactly 32 strobes, code_count=32, and the stream completes without hanging.
- Download ends after 10 bytes of record 2 → record 1 delivered, no second strobe, code_count=1.
- New ioctl_download rise during HIGH → strobe drops next cycle, codes_reset high for 4 cycles, code=0, code_count=0.
- Byte written at the same cycle as download rise → byte ignored, and the next record assembles correctly from slot 0.
